// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO on clk, decodes management frames,
// strobes a register port and drives read data back onto the shared MDIO line.
module mdio_slave #(
  parameter int PRE_MIN  = 32,
  parameter bit BCAST_EN = 1'b1,
  parameter int TO_CYC   = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  phy_addr,
  input  logic        mdc,
  inout  wire         mdio,
  output logic [4:0]  reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  output logic        frame_err,
  output logic [2:0]  dbg_state_o,
  output logic        dbg_mdio_oe_o
);

  // Register port: reg_wr_en / reg_rd_en are single-clk strobes with no back-pressure;
  // reg_rd_data is captured on the clk following reg_rd_en.
  localparam int PCW = $clog2(PRE_MIN + 1);
  localparam int TOW = $clog2(TO_CYC + 1);
  localparam logic [PCW-1:0] PRE_FULL = PCW'(PRE_MIN);
  localparam logic [TOW-1:0] TO_MAX   = TOW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_PRE, S_ST1, S_HDR, S_SKIP, S_WTA, S_WDAT, S_RTA, S_RDAT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      mdc_s_q;
  logic [1:0]      mdio_s_q;
  logic [PCW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     sh_q, sh_d;
  logic            ta_q, ta_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic            rd_lat_q, rd_lat_d;
  logic            oe_q, oe_d;
  logic            out_q, out_d;
  logic [4:0]      reg_addr_q, reg_addr_d;
  logic            wr_en_q, wr_en_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            rd_en_q, rd_en_d;
  logic            err_q, err_d;

  logic            rise, fall, mdio_bit;
  logic [11:0]     hdr;
  logic [1:0]      op;
  logic            addr_hit;

  // mdc_s_q: [0]/[1] synchroniser, [2] previous synchronised value for edge detect
  assign rise     = mdc_s_q[1] & ~mdc_s_q[2];
  assign fall     = ~mdc_s_q[1] & mdc_s_q[2];
  assign mdio_bit = mdio_s_q[1];
  assign hdr      = {sh_q[10:0], mdio_bit};
  assign op       = hdr[11:10];
  assign addr_hit = (hdr[9:5] == phy_addr) || (BCAST_EN && (hdr[9:5] == 5'd0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_PRE;
      mdc_s_q    <= '0;
      mdio_s_q   <= '0;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      ta_q       <= 1'b0;
      to_cnt_q   <= '0;
      rd_lat_q   <= 1'b0;
      oe_q       <= 1'b0;
      out_q      <= 1'b0;
      reg_addr_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdc_s_q    <= {mdc_s_q[1:0], mdc};
      mdio_s_q   <= {mdio_s_q[0], mdio};
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      ta_q       <= ta_d;
      to_cnt_q   <= to_cnt_d;
      rd_lat_q   <= rd_lat_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      reg_addr_q <= reg_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    ta_d       = ta_q;
    rd_lat_d   = rd_en_q;
    oe_d       = oe_q;
    out_d      = out_q;
    reg_addr_d = reg_addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    err_d      = 1'b0;
    to_cnt_d   = rise ? '0 : ((to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1);

    if (rd_lat_q) sh_d = reg_rd_data;

    unique case (state_q)
      S_PRE: if (rise) begin
        if (mdio_bit) begin
          if (pre_cnt_q < PRE_FULL) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if (pre_cnt_q == PRE_FULL) begin
          state_d   = S_ST1;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = '0;
        end
      end
      S_ST1: if (rise) begin
        bit_cnt_d = '0;
        if (mdio_bit) begin
          state_d = S_HDR;
        end else begin
          err_d     = 1'b1;
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      end
      S_HDR: if (rise) begin
        sh_d      = {sh_q[14:0], mdio_bit};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd11) begin
          bit_cnt_d = '0;
          if (op != 2'b01 && op != 2'b10) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end else if (!addr_hit) begin
            state_d = S_SKIP;
          end else begin
            reg_addr_d = hdr[4:0];
            if (op == 2'b01) begin
              state_d = S_WTA;
            end else begin
              state_d = S_RTA;
              rd_en_d = 1'b1;
            end
          end
        end
      end
      // Counts TA+DATA rises; a bad write TA enters here with two already consumed.
      S_SKIP: if (rise) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd17) begin
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      end
      S_WTA: if (rise) begin
        if (bit_cnt_q == 5'd0) begin
          ta_d      = mdio_bit;
          bit_cnt_d = 5'd1;
        end else if ({ta_q, mdio_bit} == 2'b10) begin
          state_d   = S_WDAT;
          bit_cnt_d = '0;
        end else begin
          err_d     = 1'b1;
          state_d   = S_SKIP;
          bit_cnt_d = 5'd2;
        end
      end
      S_WDAT: if (rise) begin
        sh_d      = {sh_q[14:0], mdio_bit};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd15) begin
          wr_data_d = {sh_q[14:0], mdio_bit};
          wr_en_d   = 1'b1;
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      end
      S_RTA: begin
        if (rise) begin
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else begin
            state_d   = S_RDAT;
            bit_cnt_d = '0;
          end
        end
        if (fall && bit_cnt_q == 5'd1) begin
          oe_d  = 1'b1;
          out_d = 1'b0;
        end
      end
      S_RDAT: begin
        if (rise) bit_cnt_d = bit_cnt_q + 5'd1;
        if (fall) begin
          if (bit_cnt_q == 5'd16) begin
            oe_d      = 1'b0;
            state_d   = S_PRE;
            pre_cnt_d = '0;
          end else begin
            oe_d  = 1'b1;
            out_d = sh_q[15];
            sh_d  = {sh_q[14:0], 1'b0};
          end
        end
      end
      default: state_d = S_PRE;
    endcase

    // A stalled MDC mid-frame abandons the frame and frees the line.
    if (state_q != S_PRE && to_cnt_q == TO_MAX) begin
      err_d     = 1'b1;
      oe_d      = 1'b0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      state_d   = S_PRE;
      pre_cnt_d = '0;
    end
  end

  assign mdio          = oe_q ? out_q : 1'bz;
  assign reg_addr      = reg_addr_q;
  assign reg_wr_en     = wr_en_q;
  assign reg_wr_data   = wr_data_q;
  assign reg_rd_en     = rd_en_q;
  assign frame_err     = err_q;
  assign dbg_state_o   = state_q;
  assign dbg_mdio_oe_o = oe_q;

endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave: a station model bit-bangs MDC/MDIO frames and
// a posedge monitor tallies register-port strobes and MDIO drive.
module tb_mdio_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  phy_addr = 5'd5;
  logic        mdc = 1'b0;
  wire         mdio;
  logic        st_oe = 1'b0;
  logic        st_out = 1'b0;
  logic [4:0]  reg_addr;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data;
  logic        frame_err;
  logic [2:0]  dbg_state;
  logic        dbg_oe;
  logic [15:0] rd_mem [32];

  assign mdio        = st_oe ? st_out : 1'bz;
  assign reg_rd_data = rd_mem[reg_addr];

  mdio_slave dut (
    .clk(clk), .rstn(rstn), .phy_addr(phy_addr), .mdc(mdc), .mdio(mdio),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .frame_err(frame_err),
    .dbg_state_o(dbg_state), .dbg_mdio_oe_o(dbg_oe)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard counters fed by the monitor
  int n_cmp = 0, n_mis = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0, n_both = 0;
  int w0, r0, e0, o0;
  logic [4:0]  wr_addr_seen = '0, rd_addr_seen = '0;
  logic [15:0] wr_data_seen = '0;

  always @(posedge clk) begin
    if (reg_wr_en) begin
      n_wr++;
      wr_addr_seen = reg_addr;
      wr_data_seen = reg_wr_data;
    end
    if (reg_rd_en) begin
      n_rd++;
      rd_addr_seen = reg_addr;
    end
    if (frame_err) n_err++;
    if (dbg_oe) n_oe++;
    if (reg_wr_en && reg_rd_en) n_both++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    w0 = n_wr; r0 = n_rd; e0 = n_err; o0 = n_oe;
  endtask

  // driver tasks: station changes MDIO while MDC is low, DUT samples on rise
  task automatic mdc_cycle();
    #40 mdc = 1'b1;
    #40 mdc = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      st_oe  = 1'b1;
      st_out = v[i];
      mdc_cycle();
    end
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) send_bits(32'd1, 1);
  endtask

  task automatic station_frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                               input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d);
    send_pre(npre);
    send_bits(32'b01, 2);
    send_bits({30'd0, op}, 2);
    send_bits({27'd0, pa}, 5);
    send_bits({27'd0, ra}, 5);
    send_bits({30'd0, ta}, 2);
    send_bits({16'd0, d}, 16);
    st_oe = 1'b0;
    #100;
  endtask

  task automatic read_frame(input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] exp, input int nbits);
    send_pre(32);
    send_bits(32'b01, 2);
    send_bits(32'b10, 2);
    send_bits({27'd0, pa}, 5);
    send_bits({27'd0, ra}, 5);
    st_oe = 1'b0;
    #40 check_eq("ta1_z", {31'd0, dbg_oe}, 32'd0);
    mdc = 1'b1;
    #40 mdc = 1'b0;
    #40 check_eq("ta2_zero", {30'd0, dbg_oe, mdio}, 32'b10);
    mdc = 1'b1;
    #40 mdc = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      #40 check_eq($sformatf("rd_bit%0d", 15 - i), {30'd0, dbg_oe, mdio}, {30'd0, 1'b1, exp[15 - i]});
      mdc = 1'b1;
      #40 mdc = 1'b0;
    end
    if (nbits == 16) begin
      #40 check_eq("rd_release", {31'd0, dbg_oe}, 32'd0);
      check_eq("rd_state_pre", {29'd0, dbg_state}, 32'd0);
      #60;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rd_mem[i] = 16'h0101 * i[15:0];
    rd_mem[2] = 16'h1234;
    rd_mem[9] = 16'hBEEF;

    #30;
    check_eq("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    check_eq("rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
    check_eq("rst_err", {31'd0, frame_err}, 32'd0);
    check_eq("rst_addr_data", {11'd0, reg_addr, reg_wr_data}, 32'd0);
    check_eq("rst_oe_state", {28'd0, dbg_oe, dbg_state}, 32'd0);
    #10 rstn = 1'b1;
    #100;

    // 1: write REGAD 4 = 0xA5C3
    snap();
    station_frame(32, 2'b01, 5'd5, 5'd4, 2'b10, 16'hA5C3);
    check_eq("t1_wr_cnt", n_wr - w0, 1);
    check_eq("t1_wr_addr", {27'd0, wr_addr_seen}, 32'd4);
    check_eq("t1_wr_data", {16'd0, wr_data_seen}, 32'hA5C3);
    check_eq("t1_no_drive", n_oe - o0, 0);
    check_eq("t1_no_rd_err", (n_rd - r0) + (n_err - e0), 0);

    // 2: read REGAD 2 -> 0x1234
    snap();
    read_frame(5'd5, 5'd2, 16'h1234, 16);
    check_eq("t2_rd_cnt", n_rd - r0, 1);
    check_eq("t2_rd_addr", {27'd0, rd_addr_seen}, 32'd2);
    check_eq("t2_no_wr_err", (n_wr - w0) + (n_err - e0), 0);

    // 3: other PHY (write and read opcodes) ignored, then back-to-back write accepted
    snap();
    station_frame(32, 2'b01, 5'd6, 5'd3, 2'b10, 16'hFFFF);
    station_frame(32, 2'b10, 5'd6, 5'd2, 2'b10, 16'h0000);
    check_eq("t3_skip_strobes", (n_wr - w0) + (n_rd - r0) + (n_err - e0), 0);
    check_eq("t3_skip_drive", n_oe - o0, 0);
    station_frame(32, 2'b01, 5'd5, 5'd7, 2'b10, 16'h0F0F);
    check_eq("t3_wr_cnt", n_wr - w0, 1);
    check_eq("t3_wr_addr", {27'd0, wr_addr_seen}, 32'd7);
    check_eq("t3_wr_data", {16'd0, wr_data_seen}, 32'h0F0F);

    // 4: short preamble ignored; broadcast address accepted
    snap();
    station_frame(31, 2'b01, 5'd5, 5'd3, 2'b10, 16'h1111);
    check_eq("t4_short_pre", (n_wr - w0) + (n_err - e0), 0);
    check_eq("t4_short_state", {29'd0, dbg_state}, 32'd0);
    station_frame(32, 2'b01, 5'd0, 5'd1, 2'b10, 16'h5AA5);
    check_eq("t4_bcast_cnt", n_wr - w0, 1);
    check_eq("t4_bcast_addr", {27'd0, wr_addr_seen}, 32'd1);
    check_eq("t4_bcast_data", {16'd0, wr_data_seen}, 32'h5AA5);

    // 5a: write with TA=00, then bad OP=11
    snap();
    station_frame(32, 2'b01, 5'd5, 5'd4, 2'b00, 16'h7777);
    check_eq("t5_ta_err", n_err - e0, 1);
    check_eq("t5_ta_no_wr", n_wr - w0, 0);
    check_eq("t5_ta_state", {29'd0, dbg_state}, 32'd0);
    station_frame(32, 2'b11, 5'd5, 5'd4, 2'b10, 16'h7777);
    check_eq("t5_op_err", n_err - e0, 2);
    check_eq("t5_op_no_strobe", (n_wr - w0) + (n_rd - r0), 0);

    // 5b: MDC stalls mid-read, timeout releases the line, next read is fine
    snap();
    read_frame(5'd5, 5'd2, 16'h1234, 8);
    #40 check_eq("t5_pre_stall_drive", {31'd0, dbg_oe}, 32'd1);
    #42000;
    check_eq("t5_to_err", n_err - e0, 1);
    check_eq("t5_to_release", {28'd0, dbg_oe, dbg_state}, 32'd0);
    read_frame(5'd5, 5'd2, 16'h1234, 16);
    check_eq("t5_rd_cnt", n_rd - r0, 2);

    // 6: async reset while bit 7 is on the wire
    snap();
    read_frame(5'd5, 5'd9, 16'hBEEF, 8);
    #40 check_eq("t6_bit7", {30'd0, dbg_oe, mdio}, 32'b11);
    rstn = 1'b0;
    #1;
    check_eq("t6_rst_oe", {31'd0, dbg_oe}, 32'd0);
    check_eq("t6_rst_strobes", {29'd0, reg_wr_en, reg_rd_en, frame_err}, 32'd0);
    check_eq("t6_rst_state", {29'd0, dbg_state}, 32'd0);
    #29 rstn = 1'b1;
    #100;
    read_frame(5'd5, 5'd9, 16'hBEEF, 16);
    check_eq("t6_rd_cnt", n_rd - r0, 2);
    check_eq("t6_no_err", n_err - e0, 0);

    check_eq("never_both_strobes", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
